// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and types for the 8-digit 7-segment scan driver.
// Holds digit count, nibble/segment widths, the dash nibble code shared with
// the clock top that packs segdata, and the active-high segment patterns.
package seg_scan_driver_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned SEGDATA_W  = NUM_DIGITS * NIBBLE_W;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned SEG_PIN_W  = 8;
    localparam int unsigned BRI_W      = 4;
    localparam int unsigned IDX_W      = 3;

    // Nibble code the clock top uses for the separator dash.
    localparam logic [NIBBLE_W-1:0] SEG_DASH_NIBBLE = 4'hA;

    // Active-high segment patterns, bit order g..a.
    localparam logic [SEG_W-1:0] SEG_PAT_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_PAT_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_PAT_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_PAT_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_PAT_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_PAT_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_PAT_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_PAT_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_PAT_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_PAT_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_PAT_DASH  = 7'h40;
    localparam logic [SEG_W-1:0] SEG_PAT_BLANK = 7'h00;

    // Phase within a digit slot.
    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } phase_e;

    // Pin-level payload driven to the display, registered as one unit.
    typedef struct packed {
        logic [SEG_PIN_W-1:0]  seg_n;
        logic [NUM_DIGITS-1:0] digit_n;
    } scan_out_t;

    localparam scan_out_t SCAN_OFF = '{seg_n: '1, digit_n: '1};

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display bus between the clock top (master) and the scan driver (slave).
//   segdata    : 8 packed nibbles, digit 0 rightmost
//   brightness : 4-bit PWM level
//   seg_n      : active-low segments, [7] = dp
//   digit_n    : active-low digit enables
//   frame_tick : one-cycle pulse per frame snapshot
interface seg_scan_driver_if;
    import seg_scan_driver_pkg::*;

    logic [SEGDATA_W-1:0]  segdata;
    logic [BRI_W-1:0]      brightness;
    logic [SEG_PIN_W-1:0]  seg_n;
    logic [NUM_DIGITS-1:0] digit_n;
    logic                  frame_tick;

    modport master (
        output segdata,
        output brightness,
        input  seg_n,
        input  digit_n,
        input  frame_tick
    );

    modport slave (
        input  segdata,
        input  brightness,
        output seg_n,
        output digit_n,
        output frame_tick
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble to 7-segment decoder, active-high, bit order g..a.
//   nibble : 4-bit digit code (0-9, dash code, others blank)
//   seg_c  : segment pattern
module seg7_decode
    import seg_scan_driver_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [SEG_W-1:0]    seg_c
);

    always_comb begin
        seg_c = SEG_PAT_BLANK;
        case (nibble)
            4'd0:            seg_c = SEG_PAT_0;
            4'd1:            seg_c = SEG_PAT_1;
            4'd2:            seg_c = SEG_PAT_2;
            4'd3:            seg_c = SEG_PAT_3;
            4'd4:            seg_c = SEG_PAT_4;
            4'd5:            seg_c = SEG_PAT_5;
            4'd6:            seg_c = SEG_PAT_6;
            4'd7:            seg_c = SEG_PAT_7;
            4'd8:            seg_c = SEG_PAT_8;
            4'd9:            seg_c = SEG_PAT_9;
            SEG_DASH_NIBBLE: seg_c = SEG_PAT_DASH;
            default:         seg_c = SEG_PAT_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Scans one digit per slot with leading dead-time blanking and 4-bit PWM
// brightness; segdata/brightness are snapshotted once per frame.
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   bus    : display bus (slave side): segdata, brightness in;
//            seg_n, digit_n, frame_tick out (all registered)
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int unsigned DWELL_CYC = 3125,
    parameter int unsigned DEAD_CYC  = 25
) (
    input  logic               clk,
    input  logic               resetn,
    seg_scan_driver_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(DWELL_CYC);

    logic [CNT_W-1:0]     slot_cnt;
    logic [IDX_W-1:0]     idx;
    logic [SEGDATA_W-1:0] snap;
    logic [BRI_W-1:0]     bri_snap;
    scan_out_t            out_q;
    logic                 tick_q;

    logic                 frame_start_c;
    logic [SEGDATA_W-1:0] snap_eff_c;
    logic [BRI_W-1:0]     bri_eff_c;
    logic [NIBBLE_W-1:0]  nibble_c;
    logic [SEG_W-1:0]     dec_c;
    logic [BRI_W-1:0]     pwm_c;
    phase_e               phase_c;
    logic                 en_c;
    scan_out_t            out_next_c;

    // Decoder sits on the muxed nibble of the current digit.
    seg7_decode u_decode (
        .nibble (nibble_c),
        .seg_c  (dec_c)
    );

    // Next pin state from the current counter state. On the frame-start cycle the
    // values being captured are used directly so a zero dead time still shows the
    // fresh frame.
    always_comb begin
        frame_start_c = (slot_cnt == '0) && (idx == '0);
        snap_eff_c    = frame_start_c ? bus.segdata    : snap;
        bri_eff_c     = frame_start_c ? bus.brightness : bri_snap;
        nibble_c      = snap_eff_c[{idx, 2'b00} +: NIBBLE_W];
        pwm_c         = BRI_W'(slot_cnt - CNT_W'(DEAD_CYC));
        phase_c       = (slot_cnt < CNT_W'(DEAD_CYC)) ? PH_BLANK : PH_ON;
        en_c          = (bri_eff_c == '1) || (pwm_c < bri_eff_c);
        out_next_c    = SCAN_OFF;
        if ((phase_c == PH_ON) && en_c) begin
            out_next_c.digit_n = ~(NUM_DIGITS'(1) << idx);
            out_next_c.seg_n   = {1'b1, ~dec_c};
        end
    end

    // Slot/digit counters, frame snapshot and the registered pin outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_cnt <= '0;
            idx      <= '0;
            snap     <= '0;
            bri_snap <= '0;
            out_q    <= SCAN_OFF;
            tick_q   <= 1'b0;
        end else begin
            if (slot_cnt == CNT_W'(DWELL_CYC - 1)) begin
                slot_cnt <= '0;
                idx      <= idx + IDX_W'(1);
            end else begin
                slot_cnt <= slot_cnt + CNT_W'(1);
            end
            if (frame_start_c) begin
                snap     <= bus.segdata;
                bri_snap <= bus.brightness;
            end
            tick_q <= frame_start_c;
            out_q  <= out_next_c;
        end
    end

    assign bus.seg_n      = out_q.seg_n;
    assign bus.digit_n    = out_q.digit_n;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with short slots (20 cycles, 2 dead).
module tb_seg_scan_driver;

    localparam int DWELL = 20;
    localparam int DEAD  = 2;
    localparam int FRAME = DWELL * 8;

    typedef struct {
        logic [7:0] seg_n;
        logic [7:0] digit_n;
        logic       tick;
    } exp_t;

    logic clk;
    logic resetn;

    seg_scan_driver_if bus ();

    seg_scan_driver #(
        .DWELL_CYC (DWELL),
        .DEAD_CYC  (DEAD)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Character table: segments lit (g..a) for each nibble value.
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

    exp_t        exp_q [$];
    bit          model_run = 0;
    int          p = 0;
    logic [31:0] m_data;
    int          m_bri;

    // Reference model: p edges since reset release define slot, digit and pwm.
    exp_t        me;
    int          m_slot, m_dig, m_pwm;
    logic [3:0]  m_nib;
    always @(posedge clk) begin
        if (model_run) begin
            m_slot = p % DWELL;
            m_dig  = (p / DWELL) % 8;
            me.tick = ((p % FRAME) == 0);
            if (me.tick) begin
                m_data = bus.segdata;
                m_bri  = int'(bus.brightness);
            end
            me.seg_n   = 8'hFF;
            me.digit_n = 8'hFF;
            if (m_slot >= DEAD) begin
                m_pwm = (m_slot - DEAD) % 16;
                if (m_bri == 15 || m_pwm < m_bri) begin
                    m_nib      = 4'(m_data >> (4 * m_dig));
                    me.digit_n = ~(8'd1 << m_dig);
                    me.seg_n   = {1'b1, ~glyph[m_nib]};
                end
            end
            exp_q.push_back(me);
            p++;
        end
    end

    // Monitor: pops one expectation per cycle and checks pin-level invariants.
    exp_t       ge;
    int         blank_run = 0;
    bit         have_lit  = 0;
    logic [7:0] last_lit  = 8'hFF;
    int         tick_gap  = 0;
    bit         have_tick = 0;
    always @(negedge clk) begin
        if (model_run && exp_q.size() > 0) begin
            ge = exp_q.pop_front();
            chk("seg_n", bus.seg_n, ge.seg_n);
            chk("digit_n", bus.digit_n, ge.digit_n);
            chk("frame_tick", bus.frame_tick, ge.tick);
            chk("one_hot_low", ($countones(~bus.digit_n) <= 1) ? 1 : 0, 1);
            if (bus.digit_n != 8'hFF) begin
                if (have_lit && bus.digit_n != last_lit)
                    chk("dead_gap", (blank_run >= DEAD) ? 1 : 0, 1);
                last_lit  = bus.digit_n;
                have_lit  = 1;
                blank_run = 0;
            end else begin
                blank_run++;
            end
            tick_gap++;
            if (bus.frame_tick) begin
                if (have_tick) chk("frame_period", tick_gap, FRAME);
                have_tick = 1;
                tick_gap  = 0;
            end
        end
    end

    task automatic wait_tick();
        bit found = 0;
        for (int i = 0; i < 2 * FRAME + 40; i++) begin
            @(negedge clk);
            if (bus.frame_tick) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_tick: no frame_tick within budget at %0t", $time);
        end
    endtask

    task automatic clear_monitor();
        exp_q.delete();
        blank_run = 0;
        have_lit  = 0;
        last_lit  = 8'hFF;
        tick_gap  = 0;
        have_tick = 0;
    endtask

    initial begin
        resetn         = 1'b0;
        bus.segdata    = 32'h12A34A56;
        bus.brightness = 4'd15;
        repeat (3) @(negedge clk);
        chk("reset_seg_n", bus.seg_n, 8'hFF);
        chk("reset_digit_n", bus.digit_n, 8'hFF);
        chk("reset_frame_tick", bus.frame_tick, 0);

        @(negedge clk);
        p         = 0;
        model_run = 1;
        resetn    = 1'b1;
        wait_tick();
        wait_tick();

        // New data mid slot 3 must not appear until the next frame.
        repeat (65) @(negedge clk);
        bus.segdata = 32'h0;
        wait_tick();
        wait_tick();

        bus.brightness = 4'd0;
        wait_tick();
        bus.brightness = 4'd8;
        wait_tick();
        bus.segdata    = 32'hFEDCBA98;
        bus.brightness = 4'd15;
        wait_tick();

        for (int f = 0; f < 5; f++) begin
            repeat ($urandom_range(1, 150)) @(negedge clk);
            bus.segdata    = $urandom;
            bus.brightness = 4'($urandom_range(0, 15));
            wait_tick();
        end

        // Asynchronous reset in the middle of slot 5, away from any clock edge.
        bus.segdata    = 32'h87654321;
        bus.brightness = 4'd15;
        wait_tick();
        repeat (104) @(negedge clk);
        @(posedge clk);
        #2;
        resetn    = 1'b0;
        model_run = 0;
        clear_monitor();
        #1;
        chk("async_seg_n", bus.seg_n, 8'hFF);
        chk("async_digit_n", bus.digit_n, 8'hFF);
        chk("async_frame_tick", bus.frame_tick, 0);
        repeat (4) @(negedge clk);
        bus.segdata = 32'h24A59A13;
        p         = 0;
        model_run = 1;
        resetn    = 1'b1;
        wait_tick();
        wait_tick();
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
